operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
Decode/operand-fetch pipeline stage. It sits between instruction fetch and EX, and drives the read ports of the register file. It reads rs1/rs2, resolves RAW hazards by forwarding from EX, MEM and the register-file write port, and stalls one cycle on load-use. Results are registered into the ID/EX pipeline register using a valid/ready handshake on both sides.

Parameters:
REGISTER_WIDTH, 32 (from common package), operand and data width
REGISTER_DEPTH, 32 (from common package), architectural register count; address width is clog2(REGISTER_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  32  PC of the presented instruction
in_instr  in  32  raw RV32I instruction word
flush  in  1  branch/jump redirect; kill in-flight and incoming instructions
rf_read_enable  out  1  equal to in_valid
rf_read_address_1  out  AW  in_instr[19:15]
rf_read_address_2  out  AW  in_instr[24:20]
rf_read_data_1  in  REGISTER_WIDTH  combinational register-file read data
rf_read_data_2  in  REGISTER_WIDTH  combinational register-file read data
ex_valid, ex_is_load, ex_rd, ex_data  in  1,1,AW,RW  instruction in EX; ex_data is the ALU result
mem_valid, mem_rd, mem_data  in  1,AW,RW  instruction in MEM; mem_data is the final result, including load data
wb_write_enable, wb_write_address, wb_write_data  in  1,AW,RW  register-file write port, tapped
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX consumes the instruction
out_pc, out_instr  out  32,32  registered copies
out_rs1_data, out_rs2_data  out  RW  registered, forwarded operands
out_rd  out  AW  in_instr[11:7]

Behaviour:
- Reset, synchronous: out_valid=0 and all out_* = 0 on the first clk edge with rst=1. rst overrides flush and the handshake.
- Latency: 1 cycle from acceptance to out_valid.
- Source usage:
  - rs1 is used unless opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - rs2 is used only for opcodes OP (0110011), STORE (0100011) and BRANCH (1100011).
- Forward select, per operand, highest priority first:
  - ex: ex_valid && !ex_is_load && ex_rd==rs && rs!=0 → ex_data
  - mem: mem_valid && mem_rd==rs && rs!=0 → mem_data
  - wb: wb_write_enable && wb_write_address==rs && rs!=0 → wb_write_data
  - otherwise rf_read_data
  - rs==0 always yields 0. The register file writes on the clock edge, so the wb bypass is mandatory.
- Load-use stall: ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches a used source.
  - in_ready=0 this cycle.
  - If the output register can advance (!out_valid || out_ready), load a bubble (out_valid<=0).
  - The next cycle, the load is in MEM and the mem forward resolves the operand.
- Accept: accept = in_valid && in_ready.
  - in_ready = !load_use && (!out_valid || out_ready).
  - On accept, all out_* load and out_valid<=1.
- Hold: when out_valid && !out_ready, all out_* remain stable and in_ready=0.
- Drain: when out_ready && !accept, out_valid<=0.
- Flush:
  - out_valid<=0 on the next edge, regardless of out_ready.
  - in_ready=1 so fetch drains; any accepted instruction is dropped.
  - Flush overrides load-use.
- Simultaneous wb write and read of the same register: the wb value wins, unless ex or mem also match.
- out_* data fields are don't-care while out_valid=0, except after reset, where they are 0.

Decomposition:
- common package: REGISTER_WIDTH, REGISTER_DEPTH, an opcode_t enum (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), and a typedef id_ex_t struct {pc, instr, rs1_data, rs2_data, rd}.
- One sub-module, forward_mux. It is combinational and instantiated twice, once per operand. It takes rs, rf data and the three forward sources, and returns the operand.

Test Plan:
- No hazard: x5=0x11 in the RF, instr add x1,x5,x0 (0x000280B3) → one cycle later out_valid=1, out_rs1_data=0x11, out_rs2_data=0.
- EX forward: ex_valid=1, ex_rd=5, ex_data=0xAA; mem_rd=5, mem_data=0xBB; wb writes 0xCC to x5 → out_rs1_data=0xAA. Drop ex → 0xBB. Drop mem → 0xCC.
- Load-use: ex_is_load=1, ex_rd=5, instr uses rs1=5 → in_ready=0 for 1 cycle and a bubble is output. Next cycle mem_data=0x1234 → out_rs1_data=0x1234.
- Back-pressure: hold out_ready=0 for 3 cycles → out_* stable, in_ready=0; release → next instruction accepted the same cycle.
- x0 and flush: rs1=0 with ex_rd=0, ex_data=0xFF → operand 0. Assert flush while out_valid=1 and out_ready=0 → out_valid=0 the next cycle.
- Reset mid-operation: rst=1 with out_valid=1 and a stall active → out_valid=0, all out_*=0 after one edge; in_ready=1 after rst drops.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, RV32I opcode encodings and the ID/EX bundle
// used by the operand-fetch stage.
package operand_fetch_stage_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;
  localparam int AW = $clog2(REGISTER_DEPTH);

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } opcode_t;

  typedef struct packed {
    logic [31:0]               pc;
    logic [31:0]               instr;
    logic [REGISTER_WIDTH-1:0] rs1_data;
    logic [REGISTER_WIDTH-1:0] rs2_data;
    logic [AW-1:0]             rd;
  } id_ex_t;

endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// Per-operand bypass select: EX, then MEM, then the RF write
// port, then the RF read data; x0 always reads as zero.
module forward_mux
  import operand_fetch_stage_pkg::*;
(
  input  logic [AW-1:0]             rs,
  input  logic [REGISTER_WIDTH-1:0] rf_data,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [AW-1:0]             ex_rd,
  input  logic [REGISTER_WIDTH-1:0] ex_data,
  input  logic                      mem_valid,
  input  logic [AW-1:0]             mem_rd,
  input  logic [REGISTER_WIDTH-1:0] mem_data,
  input  logic                      wb_write_enable,
  input  logic [AW-1:0]             wb_write_address,
  input  logic [REGISTER_WIDTH-1:0] wb_write_data,
  output logic [REGISTER_WIDTH-1:0] operand
);

  logic nz;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign nz      = (rs != '0);
  assign hit_ex  = nz && ex_valid && !ex_is_load
                   && (ex_rd == rs);
  assign hit_mem = nz && mem_valid && (mem_rd == rs);
  assign hit_wb  = nz && wb_write_enable
                   && (wb_write_address == rs);

  always_comb begin
    operand = rf_data;
    if (!nz)          operand = '0;
    else if (hit_ex)  operand = ex_data;
    else if (hit_mem) operand = mem_data;
    else if (hit_wb)  operand = wb_write_data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: RF read, EX/MEM/WB bypass,
// load-use stall and a handshaked ID/EX register.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_instr,
  input  logic                      flush,
  output logic                      rf_read_enable,
  output logic [AW-1:0]             rf_read_address_1,
  output logic [AW-1:0]             rf_read_address_2,
  input  logic [REGISTER_WIDTH-1:0] rf_read_data_1,
  input  logic [REGISTER_WIDTH-1:0] rf_read_data_2,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [AW-1:0]             ex_rd,
  input  logic [REGISTER_WIDTH-1:0] ex_data,
  input  logic                      mem_valid,
  input  logic [AW-1:0]             mem_rd,
  input  logic [REGISTER_WIDTH-1:0] mem_data,
  input  logic                      wb_write_enable,
  input  logic [AW-1:0]             wb_write_address,
  input  logic [REGISTER_WIDTH-1:0] wb_write_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_instr,
  output logic [REGISTER_WIDTH-1:0] out_rs1_data,
  output logic [REGISTER_WIDTH-1:0] out_rs2_data,
  output logic [AW-1:0]             out_rd
);

  logic [6:0]                op;
  logic [AW-1:0]             rs1;
  logic [AW-1:0]             rs2;
  logic                      use_rs1;
  logic                      use_rs2;
  logic                      load_use;
  logic                      advance;
  logic                      accept;
  logic [REGISTER_WIDTH-1:0] op1;
  logic [REGISTER_WIDTH-1:0] op2;

  logic   valid_d, valid_q;
  id_ex_t stage_d, stage_q;

  assign op  = in_instr[6:0];
  assign rs1 = in_instr[15 +: AW];
  assign rs2 = in_instr[20 +: AW];

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (op)
      LUI, AUIPC, JAL:   use_rs1 = 1'b0;
      OP, STORE, BRANCH: use_rs2 = 1'b1;
      default: ;
    endcase
  end

  // A load in EX has no data yet; wait one cycle for MEM bypass.
  assign load_use = ex_valid && ex_is_load
                    && (ex_rd != '0)
                    && ((use_rs1 && ex_rd == rs1)
                     || (use_rs2 && ex_rd == rs2));

  assign advance  = !valid_q || out_ready;
  assign in_ready = flush || (!load_use && advance);
  assign accept   = in_valid && in_ready;

  assign rf_read_enable    = in_valid;
  assign rf_read_address_1 = rs1;
  assign rf_read_address_2 = rs2;

  forward_mux u_fwd_rs1 (
    .rs               (rs1),
    .rf_data          (rf_read_data_1),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .ex_data          (ex_data),
    .mem_valid        (mem_valid),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .wb_write_enable  (wb_write_enable),
    .wb_write_address (wb_write_address),
    .wb_write_data    (wb_write_data),
    .operand          (op1)
  );

  forward_mux u_fwd_rs2 (
    .rs               (rs2),
    .rf_data          (rf_read_data_2),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .ex_data          (ex_data),
    .mem_valid        (mem_valid),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .wb_write_enable  (wb_write_enable),
    .wb_write_address (wb_write_address),
    .wb_write_data    (wb_write_data),
    .operand          (op2)
  );

  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d           = 1'b1;
      stage_d.pc        = in_pc;
      stage_d.instr     = in_instr;
      stage_d.rs1_data  = op1;
      stage_d.rs2_data  = op2;
      stage_d.rd        = in_instr[7 +: AW];
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = stage_q.pc;
  assign out_instr    = stage_q.instr;
  assign out_rs1_data = stage_q.rs1_data;
  assign out_rs2_data = stage_q.rs2_data;
  assign out_rd       = stage_q.rd;

endmodule
